// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/starve_prio_arb.sv
// Two-way grant pick: the data port normally wins, but fetch is forced through
// after STARVE_MAX consecutive data wins while it waits.
module starve_prio_arb
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved = (starve_cnt == CNT_MAX);

    // Grants are held off while reset is asserted so every output reads 0.
    assign if_gnt = nrst & if_req & (~d_req | starved);
    assign d_gnt  = nrst & d_req & ~(if_req & starved);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between fetch and load/store, and routes
// the registered read data back to whichever port owned the previous access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [1:0]      owner_state
);

    owner_e state;

    starve_prio_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk    (clk),
        .nrst   (nrst),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    // Owner of the access whose read data arrives this cycle; fully pipelined.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= OWN_NONE;
        end else if (if_gnt) begin
            state <= OWN_IF;
        end else if (d_gnt) begin
            state <= OWN_D;
        end else begin
            state <= OWN_NONE;
        end
    end

    assign owner_state = state;

    always_comb begin
        mem_en    = if_gnt | d_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_addr = if_addr;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    assign if_rvalid = (state == OWN_IF);
    assign d_rvalid  = (state == OWN_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares a single-port synchronous memory between the instruction fetch port and the execute-stage load/store port. It decides each cycle which requester drives the memory and routes the registered read data back to the owner one cycle later. It also enforces fetch anti-starvation with a bounded-priority counter. The arbiter sits between the fetch stage, the execute-stage memory wrapper and the shared RAM macro.

## Interface
- AW, 32, address width (word address)
- DW, 32, data width
- STARVE_MAX, 4, max consecutive data-port wins while fetch waits; range 1..15
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_be  in  DW/8  store byte enables
- d_addr  in  AW  load/store address
- d_wdata  in  DW  store data
- d_gnt  out  1  load/store request accepted this cycle
- d_rvalid  out  1  load data valid or store acknowledge
- d_rdata  out  DW  load data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en

## Operation
- Requesters hold req and all request fields stable until gnt. A deasserted req never receives gnt.
- Arbitration is combinational per cycle:
  - Only one requester active: that requester is granted.
  - Both active: d wins unless starve_cnt == STARVE_MAX, in which case if wins.
- starve_cnt (width $clog2(STARVE_MAX+1)):
  - Increments when if_req && d_gnt.
  - Clears to 0 when if_gnt, or when if_req == 0.
  - Saturates at STARVE_MAX.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - mem_addr, mem_we, mem_be and mem_wdata come from the winner.
  - A fetch drives mem_we=0, mem_be=0, mem_wdata=0.
  - With no grant, all mem_* outputs are 0.
- Owner FSM, one register, states OWN_NONE, OWN_IF, OWN_D:
  - The next state is OWN_IF if if_gnt, OWN_D if d_gnt, else OWN_NONE.
  - Any state can transition to any state every cycle, so grants are fully pipelined.
- Response routing:
  - if_rvalid = (state == OWN_IF).
  - d_rvalid = (state == OWN_D). This applies to stores as well: the acknowledge comes 1 cycle after grant.
  - if_rdata and d_rdata each equal mem_rdata while the port's rvalid is high, else 0.
  - d_rdata for a store acknowledge is don't-care. The bench must not check it.

## Timing
- Reset values: every output 0, state OWN_NONE, starve_cnt 0.
- gnt has 0-cycle latency from req (combinational). rvalid follows gnt by exactly 1 cycle.
- Throughput is one access per cycle. A gnt and the previous access's rvalid to the same or other port may coincide.
- Simultaneous events:
  - Both requesting with starve_cnt < STARVE_MAX: d_gnt=1, if_gnt=0, counter +1.
  - At starve_cnt == STARVE_MAX: if_gnt=1, counter goes to 0 next cycle.
- Reset asserted mid-access: the outstanding response is dropped, rvalid is low from reset onward, and the counter is cleared. Deassertion is synchronized by the surrounding reset logic.
- There is no combinational path from mem_rdata to any gnt.

## Structure
- The shared package holds:
  - typedef enum logic [1:0] owner_e {OWN_NONE, OWN_IF, OWN_D}.
  - The STARVE_MAX default constant.
- One sub-module, starve_prio_arb, holds the two-way priority pick and the starve counter. Its outputs are if_gnt and d_gnt. The top level keeps the owner FSM, the mux and response routing.

## Test plan
- Fetch only: if_req=1, if_addr=0x10 for 3 cycles -> if_gnt=1 each cycle; mem_addr=0x10, mem_we=0; if_rvalid=1 on cycles 2..4 with if_rdata=mem_rdata.
- Store then load, back-to-back: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, d_be=0xF, then d_we=0, d_addr=0x20 -> mem_we=1 then mem_we=0 on consecutive cycles; d_rvalid high 2 cycles; the load returns 0xDEADBEEF.
- Contention with STARVE_MAX=4: if_req and d_req both held high -> d_gnt for 4 cycles, then if_gnt for 1 cycle, and the pattern repeats (4:1).
- Fetch drops its request: both requesting for 2 cycles, then if_req=0 for 1 cycle, then both requesting again -> starve_cnt returns to 0, and 4 more d wins follow before the next if_gnt.
- Reset mid-access: d_gnt in cycle N, nrst low in cycle N+1 before the clock edge -> d_rvalid=0, all mem_* outputs 0, state OWN_NONE. After release, the first request is granted normally.
- Idle: no requests for 5 cycles -> mem_en=0, and both gnt and both rvalid stay 0.
